// File: rtl/axi4_echo_pkg.sv
// Shared widths, echo field offsets and the echo record carried alongside
// each AXI4 request until its response returns.
package axi4_echo_pkg;

  localparam int ID_W = 4;
  localparam int ECHO_W = 14;

  localparam int SIZE_LSB = 0;
  localparam int SIZE_W = 4;
  localparam int SOURCE_LSB = 4;
  localparam int SOURCE_W = 7;
  localparam int EXTRA_LSB = 11;
  localparam int EXTRA_W = 3;

  typedef struct packed {
    logic [EXTRA_W-1:0]  extra_id;
    logic [SOURCE_W-1:0] tl_state_source;
    logic [SIZE_W-1:0]   tl_state_size;
  } echo_t;

endpackage

// File: rtl/axi4_echo_fifo.sv
// Single DEPTH-entry echo FIFO; full/empty come only from the registered count.
module axi4_echo_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 14
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  import axi4_echo_pkg::*;

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr_reg];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= next_ptr(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= next_ptr(rd_ptr_reg);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Payload storage is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

endmodule

// File: rtl/axi4_user_yanker.sv
// Strips echo fields off AXI4 requests, parks them in per-ID FIFOs and
// reattaches them to the matching B/R responses.
module axi4_user_yanker #(
  parameter int ID_W = 4,
  parameter int DEPTH = 2,
  parameter int ECHO_W = 14
) (
  input  logic            clock,
  input  logic            reset,
  output logic            auto_in_aw_ready,
  input  logic            auto_in_aw_valid,
  input  logic [ID_W-1:0] auto_in_aw_bits_id,
  input  logic [31:0]     auto_in_aw_bits_addr,
  input  logic [7:0]      auto_in_aw_bits_len,
  input  logic [2:0]      auto_in_aw_bits_size,
  input  logic [1:0]      auto_in_aw_bits_burst,
  input  logic            auto_in_aw_bits_lock,
  input  logic [3:0]      auto_in_aw_bits_cache,
  input  logic [2:0]      auto_in_aw_bits_prot,
  input  logic [3:0]      auto_in_aw_bits_qos,
  input  logic [3:0]      auto_in_aw_echo_tl_state_size,
  input  logic [6:0]      auto_in_aw_echo_tl_state_source,
  input  logic [2:0]      auto_in_aw_echo_extra_id,
  output logic            auto_in_w_ready,
  input  logic            auto_in_w_valid,
  input  logic [63:0]     auto_in_w_bits_data,
  input  logic [7:0]      auto_in_w_bits_strb,
  input  logic            auto_in_w_bits_last,
  input  logic            auto_in_b_ready,
  output logic            auto_in_b_valid,
  output logic [ID_W-1:0] auto_in_b_bits_id,
  output logic [1:0]      auto_in_b_bits_resp,
  output logic [3:0]      auto_in_b_echo_tl_state_size,
  output logic [6:0]      auto_in_b_echo_tl_state_source,
  output logic [2:0]      auto_in_b_echo_extra_id,
  output logic            auto_in_ar_ready,
  input  logic            auto_in_ar_valid,
  input  logic [ID_W-1:0] auto_in_ar_bits_id,
  input  logic [31:0]     auto_in_ar_bits_addr,
  input  logic [7:0]      auto_in_ar_bits_len,
  input  logic [2:0]      auto_in_ar_bits_size,
  input  logic [1:0]      auto_in_ar_bits_burst,
  input  logic            auto_in_ar_bits_lock,
  input  logic [3:0]      auto_in_ar_bits_cache,
  input  logic [2:0]      auto_in_ar_bits_prot,
  input  logic [3:0]      auto_in_ar_bits_qos,
  input  logic [3:0]      auto_in_ar_echo_tl_state_size,
  input  logic [6:0]      auto_in_ar_echo_tl_state_source,
  input  logic [2:0]      auto_in_ar_echo_extra_id,
  input  logic            auto_in_r_ready,
  output logic            auto_in_r_valid,
  output logic [ID_W-1:0] auto_in_r_bits_id,
  output logic [63:0]     auto_in_r_bits_data,
  output logic [1:0]      auto_in_r_bits_resp,
  output logic            auto_in_r_bits_last,
  output logic [3:0]      auto_in_r_echo_tl_state_size,
  output logic [6:0]      auto_in_r_echo_tl_state_source,
  output logic [2:0]      auto_in_r_echo_extra_id,
  input  logic            auto_out_aw_ready,
  output logic            auto_out_aw_valid,
  output logic [ID_W-1:0] auto_out_aw_bits_id,
  output logic [31:0]     auto_out_aw_bits_addr,
  output logic [7:0]      auto_out_aw_bits_len,
  output logic [2:0]      auto_out_aw_bits_size,
  output logic [1:0]      auto_out_aw_bits_burst,
  output logic            auto_out_aw_bits_lock,
  output logic [3:0]      auto_out_aw_bits_cache,
  output logic [2:0]      auto_out_aw_bits_prot,
  output logic [3:0]      auto_out_aw_bits_qos,
  input  logic            auto_out_w_ready,
  output logic            auto_out_w_valid,
  output logic [63:0]     auto_out_w_bits_data,
  output logic [7:0]      auto_out_w_bits_strb,
  output logic            auto_out_w_bits_last,
  output logic            auto_out_b_ready,
  input  logic            auto_out_b_valid,
  input  logic [ID_W-1:0] auto_out_b_bits_id,
  input  logic [1:0]      auto_out_b_bits_resp,
  input  logic            auto_out_ar_ready,
  output logic            auto_out_ar_valid,
  output logic [ID_W-1:0] auto_out_ar_bits_id,
  output logic [31:0]     auto_out_ar_bits_addr,
  output logic [7:0]      auto_out_ar_bits_len,
  output logic [2:0]      auto_out_ar_bits_size,
  output logic [1:0]      auto_out_ar_bits_burst,
  output logic            auto_out_ar_bits_lock,
  output logic [3:0]      auto_out_ar_bits_cache,
  output logic [2:0]      auto_out_ar_bits_prot,
  output logic [3:0]      auto_out_ar_bits_qos,
  output logic            auto_out_r_ready,
  input  logic            auto_out_r_valid,
  input  logic [ID_W-1:0] auto_out_r_bits_id,
  input  logic [63:0]     auto_out_r_bits_data,
  input  logic [1:0]      auto_out_r_bits_resp,
  input  logic            auto_out_r_bits_last,
  output logic            resp_err
);
  import axi4_echo_pkg::*;

  localparam int N = 1 << ID_W;

  logic [N-1:0]      aw_full, aw_empty, ar_full, ar_empty;
  logic [N-1:0]      aw_push, b_pop, ar_push, r_pop;
  logic [ECHO_W-1:0] aw_head [N];
  logic [ECHO_W-1:0] ar_head [N];
  logic [ECHO_W-1:0] aw_echo, ar_echo, b_echo, r_echo;
  logic              aw_fire, ar_fire, b_fire, r_fire;
  logic              b_miss, r_miss;
  logic              resp_err_reg;

  assign aw_echo = ECHO_W'({auto_in_aw_echo_extra_id, auto_in_aw_echo_tl_state_source,
                            auto_in_aw_echo_tl_state_size});
  assign ar_echo = ECHO_W'({auto_in_ar_echo_extra_id, auto_in_ar_echo_tl_state_source,
                            auto_in_ar_echo_tl_state_size});

  assign auto_out_aw_valid = auto_in_aw_valid & ~aw_full[auto_in_aw_bits_id];
  assign auto_in_aw_ready  = auto_out_aw_ready & ~aw_full[auto_in_aw_bits_id];
  assign auto_out_ar_valid = auto_in_ar_valid & ~ar_full[auto_in_ar_bits_id];
  assign auto_in_ar_ready  = auto_out_ar_ready & ~ar_full[auto_in_ar_bits_id];

  assign aw_fire = auto_in_aw_valid & auto_in_aw_ready;
  assign ar_fire = auto_in_ar_valid & auto_in_ar_ready;
  assign b_fire  = auto_out_b_valid & auto_in_b_ready;
  assign r_fire  = auto_out_r_valid & auto_in_r_ready;
  assign b_miss  = aw_empty[auto_out_b_bits_id];
  assign r_miss  = ar_empty[auto_out_r_bits_id];

  assign auto_out_aw_bits_id    = auto_in_aw_bits_id;
  assign auto_out_aw_bits_addr  = auto_in_aw_bits_addr;
  assign auto_out_aw_bits_len   = auto_in_aw_bits_len;
  assign auto_out_aw_bits_size  = auto_in_aw_bits_size;
  assign auto_out_aw_bits_burst = auto_in_aw_bits_burst;
  assign auto_out_aw_bits_lock  = auto_in_aw_bits_lock;
  assign auto_out_aw_bits_cache = auto_in_aw_bits_cache;
  assign auto_out_aw_bits_prot  = auto_in_aw_bits_prot;
  assign auto_out_aw_bits_qos   = auto_in_aw_bits_qos;
  assign auto_out_ar_bits_id    = auto_in_ar_bits_id;
  assign auto_out_ar_bits_addr  = auto_in_ar_bits_addr;
  assign auto_out_ar_bits_len   = auto_in_ar_bits_len;
  assign auto_out_ar_bits_size  = auto_in_ar_bits_size;
  assign auto_out_ar_bits_burst = auto_in_ar_bits_burst;
  assign auto_out_ar_bits_lock  = auto_in_ar_bits_lock;
  assign auto_out_ar_bits_cache = auto_in_ar_bits_cache;
  assign auto_out_ar_bits_prot  = auto_in_ar_bits_prot;
  assign auto_out_ar_bits_qos   = auto_in_ar_bits_qos;

  assign auto_out_w_valid     = auto_in_w_valid;
  assign auto_in_w_ready      = auto_out_w_ready;
  assign auto_out_w_bits_data = auto_in_w_bits_data;
  assign auto_out_w_bits_strb = auto_in_w_bits_strb;
  assign auto_out_w_bits_last = auto_in_w_bits_last;

  assign auto_in_b_valid     = auto_out_b_valid;
  assign auto_out_b_ready    = auto_in_b_ready;
  assign auto_in_b_bits_id   = auto_out_b_bits_id;
  assign auto_in_b_bits_resp = auto_out_b_bits_resp;
  assign auto_in_r_valid     = auto_out_r_valid;
  assign auto_out_r_ready    = auto_in_r_ready;
  assign auto_in_r_bits_id   = auto_out_r_bits_id;
  assign auto_in_r_bits_data = auto_out_r_bits_data;
  assign auto_in_r_bits_resp = auto_out_r_bits_resp;
  assign auto_in_r_bits_last = auto_out_r_bits_last;

  // A response with nothing queued reports a zero echo rather than stale data.
  assign b_echo = b_miss ? '0 : aw_head[auto_out_b_bits_id];
  assign r_echo = r_miss ? '0 : ar_head[auto_out_r_bits_id];

  assign auto_in_b_echo_tl_state_size   = b_echo[SIZE_LSB +: SIZE_W];
  assign auto_in_b_echo_tl_state_source = b_echo[SOURCE_LSB +: SOURCE_W];
  assign auto_in_b_echo_extra_id        = b_echo[EXTRA_LSB +: EXTRA_W];
  assign auto_in_r_echo_tl_state_size   = r_echo[SIZE_LSB +: SIZE_W];
  assign auto_in_r_echo_tl_state_source = r_echo[SOURCE_LSB +: SOURCE_W];
  assign auto_in_r_echo_extra_id        = r_echo[EXTRA_LSB +: EXTRA_W];

  for (genvar gi = 0; gi < N; gi++) begin : g_bank
    assign aw_push[gi] = aw_fire & (auto_in_aw_bits_id == ID_W'(gi));
    assign ar_push[gi] = ar_fire & (auto_in_ar_bits_id == ID_W'(gi));
    assign b_pop[gi]   = b_fire & (auto_out_b_bits_id == ID_W'(gi));
    assign r_pop[gi]   = r_fire & auto_out_r_bits_last & (auto_out_r_bits_id == ID_W'(gi));

    axi4_echo_fifo #(.DEPTH(DEPTH), .W(ECHO_W)) u_aw_fifo (
      .clock (clock),
      .reset (reset),
      .push  (aw_push[gi]),
      .pop   (b_pop[gi]),
      .din   (aw_echo),
      .head  (aw_head[gi]),
      .full  (aw_full[gi]),
      .empty (aw_empty[gi])
    );

    axi4_echo_fifo #(.DEPTH(DEPTH), .W(ECHO_W)) u_ar_fifo (
      .clock (clock),
      .reset (reset),
      .push  (ar_push[gi]),
      .pop   (r_pop[gi]),
      .din   (ar_echo),
      .head  (ar_head[gi]),
      .full  (ar_full[gi]),
      .empty (ar_empty[gi])
    );
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) resp_err_reg <= 1'b0;
    else if ((b_fire & b_miss) | (r_fire & r_miss)) resp_err_reg <= 1'b1;
  end

  assign resp_err = resp_err_reg;

endmodule

// File: tb/tb_axi4_user_yanker.sv
// Randomised scoreboard bench: a queue-based model of per-ID outstanding
// echoes predicts handshakes, echoes and the sticky error flag.
module tb_axi4_user_yanker;
  localparam int ID_W = 4;
  localparam int DEPTH = 2;
  localparam int ECHO_W = 14;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic            in_aw_ready, in_aw_valid, in_aw_lock;
  logic [ID_W-1:0] in_aw_id;
  logic [31:0]     in_aw_addr;
  logic [7:0]      in_aw_len;
  logic [2:0]      in_aw_size, in_aw_prot;
  logic [1:0]      in_aw_burst;
  logic [3:0]      in_aw_cache, in_aw_qos, in_aw_esz;
  logic [6:0]      in_aw_esrc;
  logic [2:0]      in_aw_eex;
  logic            in_ar_ready, in_ar_valid, in_ar_lock;
  logic [ID_W-1:0] in_ar_id;
  logic [31:0]     in_ar_addr;
  logic [7:0]      in_ar_len;
  logic [2:0]      in_ar_size, in_ar_prot;
  logic [1:0]      in_ar_burst;
  logic [3:0]      in_ar_cache, in_ar_qos, in_ar_esz;
  logic [6:0]      in_ar_esrc;
  logic [2:0]      in_ar_eex;
  logic            in_w_ready, in_w_valid, in_w_last;
  logic [63:0]     in_w_data;
  logic [7:0]      in_w_strb;
  logic            in_b_ready, in_b_valid;
  logic [ID_W-1:0] in_b_id;
  logic [1:0]      in_b_resp;
  logic [3:0]      in_b_esz;
  logic [6:0]      in_b_esrc;
  logic [2:0]      in_b_eex;
  logic            in_r_ready, in_r_valid, in_r_last;
  logic [ID_W-1:0] in_r_id;
  logic [63:0]     in_r_data;
  logic [1:0]      in_r_resp;
  logic [3:0]      in_r_esz;
  logic [6:0]      in_r_esrc;
  logic [2:0]      in_r_eex;
  logic            out_aw_ready, out_aw_valid, out_aw_lock;
  logic [ID_W-1:0] out_aw_id;
  logic [31:0]     out_aw_addr;
  logic [7:0]      out_aw_len;
  logic [2:0]      out_aw_size, out_aw_prot;
  logic [1:0]      out_aw_burst;
  logic [3:0]      out_aw_cache, out_aw_qos;
  logic            out_w_ready, out_w_valid, out_w_last;
  logic [63:0]     out_w_data;
  logic [7:0]      out_w_strb;
  logic            out_b_ready, out_b_valid;
  logic [ID_W-1:0] out_b_id;
  logic [1:0]      out_b_resp;
  logic            out_ar_ready, out_ar_valid, out_ar_lock;
  logic [ID_W-1:0] out_ar_id;
  logic [31:0]     out_ar_addr;
  logic [7:0]      out_ar_len;
  logic [2:0]      out_ar_size, out_ar_prot;
  logic [1:0]      out_ar_burst;
  logic [3:0]      out_ar_cache, out_ar_qos;
  logic            out_r_ready, out_r_valid, out_r_last;
  logic [ID_W-1:0] out_r_id;
  logic [63:0]     out_r_data;
  logic [1:0]      out_r_resp;
  logic            resp_err;

  axi4_user_yanker #(.ID_W(ID_W), .DEPTH(DEPTH), .ECHO_W(ECHO_W)) dut (
    .clock(clock), .reset(reset),
    .auto_in_aw_ready(in_aw_ready), .auto_in_aw_valid(in_aw_valid),
    .auto_in_aw_bits_id(in_aw_id), .auto_in_aw_bits_addr(in_aw_addr),
    .auto_in_aw_bits_len(in_aw_len), .auto_in_aw_bits_size(in_aw_size),
    .auto_in_aw_bits_burst(in_aw_burst), .auto_in_aw_bits_lock(in_aw_lock),
    .auto_in_aw_bits_cache(in_aw_cache), .auto_in_aw_bits_prot(in_aw_prot),
    .auto_in_aw_bits_qos(in_aw_qos), .auto_in_aw_echo_tl_state_size(in_aw_esz),
    .auto_in_aw_echo_tl_state_source(in_aw_esrc), .auto_in_aw_echo_extra_id(in_aw_eex),
    .auto_in_w_ready(in_w_ready), .auto_in_w_valid(in_w_valid),
    .auto_in_w_bits_data(in_w_data), .auto_in_w_bits_strb(in_w_strb),
    .auto_in_w_bits_last(in_w_last),
    .auto_in_b_ready(in_b_ready), .auto_in_b_valid(in_b_valid),
    .auto_in_b_bits_id(in_b_id), .auto_in_b_bits_resp(in_b_resp),
    .auto_in_b_echo_tl_state_size(in_b_esz), .auto_in_b_echo_tl_state_source(in_b_esrc),
    .auto_in_b_echo_extra_id(in_b_eex),
    .auto_in_ar_ready(in_ar_ready), .auto_in_ar_valid(in_ar_valid),
    .auto_in_ar_bits_id(in_ar_id), .auto_in_ar_bits_addr(in_ar_addr),
    .auto_in_ar_bits_len(in_ar_len), .auto_in_ar_bits_size(in_ar_size),
    .auto_in_ar_bits_burst(in_ar_burst), .auto_in_ar_bits_lock(in_ar_lock),
    .auto_in_ar_bits_cache(in_ar_cache), .auto_in_ar_bits_prot(in_ar_prot),
    .auto_in_ar_bits_qos(in_ar_qos), .auto_in_ar_echo_tl_state_size(in_ar_esz),
    .auto_in_ar_echo_tl_state_source(in_ar_esrc), .auto_in_ar_echo_extra_id(in_ar_eex),
    .auto_in_r_ready(in_r_ready), .auto_in_r_valid(in_r_valid),
    .auto_in_r_bits_id(in_r_id), .auto_in_r_bits_data(in_r_data),
    .auto_in_r_bits_resp(in_r_resp), .auto_in_r_bits_last(in_r_last),
    .auto_in_r_echo_tl_state_size(in_r_esz), .auto_in_r_echo_tl_state_source(in_r_esrc),
    .auto_in_r_echo_extra_id(in_r_eex),
    .auto_out_aw_ready(out_aw_ready), .auto_out_aw_valid(out_aw_valid),
    .auto_out_aw_bits_id(out_aw_id), .auto_out_aw_bits_addr(out_aw_addr),
    .auto_out_aw_bits_len(out_aw_len), .auto_out_aw_bits_size(out_aw_size),
    .auto_out_aw_bits_burst(out_aw_burst), .auto_out_aw_bits_lock(out_aw_lock),
    .auto_out_aw_bits_cache(out_aw_cache), .auto_out_aw_bits_prot(out_aw_prot),
    .auto_out_aw_bits_qos(out_aw_qos),
    .auto_out_w_ready(out_w_ready), .auto_out_w_valid(out_w_valid),
    .auto_out_w_bits_data(out_w_data), .auto_out_w_bits_strb(out_w_strb),
    .auto_out_w_bits_last(out_w_last),
    .auto_out_b_ready(out_b_ready), .auto_out_b_valid(out_b_valid),
    .auto_out_b_bits_id(out_b_id), .auto_out_b_bits_resp(out_b_resp),
    .auto_out_ar_ready(out_ar_ready), .auto_out_ar_valid(out_ar_valid),
    .auto_out_ar_bits_id(out_ar_id), .auto_out_ar_bits_addr(out_ar_addr),
    .auto_out_ar_bits_len(out_ar_len), .auto_out_ar_bits_size(out_ar_size),
    .auto_out_ar_bits_burst(out_ar_burst), .auto_out_ar_bits_lock(out_ar_lock),
    .auto_out_ar_bits_cache(out_ar_cache), .auto_out_ar_bits_prot(out_ar_prot),
    .auto_out_ar_bits_qos(out_ar_qos),
    .auto_out_r_ready(out_r_ready), .auto_out_r_valid(out_r_valid),
    .auto_out_r_bits_id(out_r_id), .auto_out_r_bits_data(out_r_data),
    .auto_out_r_bits_resp(out_r_resp), .auto_out_r_bits_last(out_r_last),
    .resp_err(resp_err)
  );

  typedef struct { int ex; int src; int sz; } echo_s;
  typedef struct {
    bit aw_ready, aw_valid, ar_ready, ar_valid, err, w_ready;
    logic [31:0] aw_addr, ar_addr;
    logic [ID_W-1:0] aw_id;
    logic [63:0] w_data, r_data;
    logic [1:0] b_resp;
  } cyc_s;

  echo_s aw_q [16][$];
  echo_s ar_q [16][$];
  bit    model_err = 1'b0;
  echo_s exp_b [$];
  echo_s exp_r [$];
  cyc_s  cyc_q [$];
  int    total = 0;
  int    bad = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=0x%0h want=0x%0h", name, act, exp);
    end
  endtask

  task automatic clr();
    in_aw_valid = 0; in_ar_valid = 0; out_b_valid = 0; out_r_valid = 0;
    out_aw_ready = 1; out_ar_ready = 1; in_b_ready = 1; in_r_ready = 1;
    in_w_valid = $urandom_range(0, 1); out_w_ready = $urandom_range(0, 1);
    in_w_data = {$urandom, $urandom}; in_w_strb = 8'($urandom); in_w_last = 1'($urandom);
    in_aw_id = 0; in_aw_addr = $urandom; in_aw_len = 8'($urandom); in_aw_size = 3'($urandom);
    in_aw_burst = 2'($urandom); in_aw_lock = 1'($urandom); in_aw_cache = 4'($urandom);
    in_aw_prot = 3'($urandom); in_aw_qos = 4'($urandom);
    in_aw_esz = 4'($urandom); in_aw_esrc = 7'($urandom); in_aw_eex = 3'($urandom);
    in_ar_id = 0; in_ar_addr = $urandom; in_ar_len = 8'($urandom); in_ar_size = 3'($urandom);
    in_ar_burst = 2'($urandom); in_ar_lock = 1'($urandom); in_ar_cache = 4'($urandom);
    in_ar_prot = 3'($urandom); in_ar_qos = 4'($urandom);
    in_ar_esz = 4'($urandom); in_ar_esrc = 7'($urandom); in_ar_eex = 3'($urandom);
    out_b_id = 0; out_b_resp = 2'($urandom);
    out_r_id = 0; out_r_data = {$urandom, $urandom}; out_r_resp = 2'($urandom); out_r_last = 0;
  endtask

  // Evaluate this cycle's inputs against the model, queue expectations, advance.
  task automatic step();
    cyc_s c;
    echo_s e;
    bit aw_acc, ar_acc;
    c.aw_ready = out_aw_ready && (aw_q[in_aw_id].size() < DEPTH);
    c.aw_valid = in_aw_valid && (aw_q[in_aw_id].size() < DEPTH);
    c.ar_ready = out_ar_ready && (ar_q[in_ar_id].size() < DEPTH);
    c.ar_valid = in_ar_valid && (ar_q[in_ar_id].size() < DEPTH);
    aw_acc = in_aw_valid && c.aw_ready;
    ar_acc = in_ar_valid && c.ar_ready;
    c.err = model_err;
    c.w_ready = out_w_ready;
    c.aw_addr = in_aw_addr; c.ar_addr = in_ar_addr; c.aw_id = in_aw_id;
    c.w_data = in_w_data; c.r_data = out_r_data; c.b_resp = out_b_resp;
    cyc_q.push_back(c);
    if (out_b_valid && in_b_ready) begin
      if (aw_q[out_b_id].size() > 0) e = aw_q[out_b_id].pop_front();
      else begin e = '{0, 0, 0}; model_err = 1'b1; end
      exp_b.push_back(e);
    end
    if (out_r_valid && in_r_ready) begin
      if (ar_q[out_r_id].size() > 0) begin
        e = ar_q[out_r_id][0];
        if (out_r_last) void'(ar_q[out_r_id].pop_front());
      end else begin
        e = '{0, 0, 0}; model_err = 1'b1;
      end
      exp_r.push_back(e);
    end
    if (aw_acc) aw_q[in_aw_id].push_back('{int'(in_aw_eex), int'(in_aw_esrc), int'(in_aw_esz)});
    if (ar_acc) ar_q[in_ar_id].push_back('{int'(in_ar_eex), int'(in_ar_esrc), int'(in_ar_esz)});
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (reset) begin
      cyc_s c;
      echo_s e;
      if (cyc_q.size() > 0) begin
        c = cyc_q.pop_front();
        chk("aw_ready", in_aw_ready, c.aw_ready);
        chk("aw_valid_out", out_aw_valid, c.aw_valid);
        chk("ar_ready", in_ar_ready, c.ar_ready);
        chk("ar_valid_out", out_ar_valid, c.ar_valid);
        chk("resp_err", resp_err, c.err);
        chk("aw_addr_pass", out_aw_addr, c.aw_addr);
        chk("aw_id_pass", out_aw_id, c.aw_id);
        chk("ar_addr_pass", out_ar_addr, c.ar_addr);
        chk("w_data_pass", out_w_data, c.w_data);
        chk("w_ready_pass", in_w_ready, c.w_ready);
        chk("r_data_pass", in_r_data, c.r_data);
        chk("b_resp_pass", in_b_resp, c.b_resp);
      end
      if (in_b_valid && in_b_ready) begin
        if (exp_b.size() == 0) chk("b_unexpected", 1, 0);
        else begin
          e = exp_b.pop_front();
          chk("b_echo_extra", in_b_eex, e.ex);
          chk("b_echo_source", in_b_esrc, e.src);
          chk("b_echo_size", in_b_esz, e.sz);
        end
      end
      if (in_r_valid && in_r_ready) begin
        if (exp_r.size() == 0) chk("r_unexpected", 1, 0);
        else begin
          e = exp_r.pop_front();
          chk("r_echo_extra", in_r_eex, e.ex);
          chk("r_echo_source", in_r_esrc, e.src);
          chk("r_echo_size", in_r_esz, e.sz);
        end
      end
    end
  end

  initial begin
    clr();
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    chk("rst_b_echo_src", in_b_esrc, 0);
    chk("rst_r_echo_src", in_r_esrc, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_aw_ready", in_aw_ready, 1);
    chk("rst_ar_ready", in_ar_ready, 1);

    // Single write echo round trip on id 3, then refill to prove it emptied.
    clr(); in_aw_valid = 1; in_aw_id = 3; in_aw_esrc = 7'h15; in_aw_esz = 3; in_aw_eex = 5; step();
    clr(); step(); step();
    clr(); out_b_valid = 1; out_b_id = 3; step();
    clr(); in_aw_valid = 1; in_aw_id = 3; step(); step(); step();
    clr(); out_b_valid = 1; out_b_id = 3; step(); step();

    // Third read on id 7 waits for a last beat, with no same-cycle bypass.
    clr(); in_ar_valid = 1; in_ar_id = 7;
    repeat (5) step();
    out_r_valid = 1; out_r_id = 7; out_r_last = 1; step();
    out_r_valid = 0; step();
    clr(); out_r_valid = 1; out_r_id = 7; out_r_last = 1; step(); step();

    // Four-beat read burst on id 2 keeps one echo until the last beat.
    clr(); in_ar_valid = 1; in_ar_id = 2; in_ar_esrc = 7'h2a; step();
    for (int i = 0; i < 4; i++) begin
      clr(); out_r_valid = 1; out_r_id = 2; out_r_last = (i == 3); step();
    end
    clr(); in_ar_valid = 1; in_ar_id = 2; step(); step(); step();
    clr(); out_r_valid = 1; out_r_id = 2; out_r_last = 1; step(); step();

    // Full id 1: pop and push in the same cycle still stalls the push.
    clr(); in_aw_valid = 1; in_aw_id = 1; step(); step();
    out_b_valid = 1; out_b_id = 1; step();
    out_b_valid = 0; step(); step();
    clr(); out_b_valid = 1; out_b_id = 1; step(); step();

    // Response with nothing outstanding raises a sticky error.
    clr(); out_b_valid = 1; out_b_id = 9; step();
    clr(); repeat (11) step();

    // Asynchronous reset in the middle of a cycle with id 4 full.
    clr(); in_aw_valid = 1; in_aw_id = 4; step(); step();
    clr(); in_aw_valid = 1; in_aw_id = 4; out_b_id = 4;
    #2 reset = 1'b0;
    #1;
    chk("arst_resp_err", resp_err, 0);
    chk("arst_aw_ready", in_aw_ready, 1);
    chk("arst_aw_valid_out", out_aw_valid, 1);
    chk("arst_b_echo_src", in_b_esrc, 0);
    for (int i = 0; i < 16; i++) begin aw_q[i].delete(); ar_q[i].delete(); end
    model_err = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
    clr(); out_b_valid = 1; out_b_id = 4; step();
    clr(); step(); step();

    for (int n = 0; n < 600; n++) begin
      clr();
      in_aw_valid = 1'($urandom); in_aw_id = 4'($urandom_range(0, 3));
      out_aw_ready = ($urandom_range(0, 3) != 0);
      in_ar_valid = 1'($urandom); in_ar_id = 4'($urandom_range(0, 3));
      out_ar_ready = ($urandom_range(0, 3) != 0);
      out_b_valid = ($urandom_range(0, 2) == 0); out_b_id = 4'($urandom_range(0, 3));
      in_b_ready = 1'($urandom);
      out_r_valid = ($urandom_range(0, 1) == 0); out_r_id = 4'($urandom_range(0, 3));
      out_r_last = 1'($urandom); in_r_ready = 1'($urandom);
      step();
    end
    clr(); step(); step();

    chk("b_queue_drained", exp_b.size(), 0);
    chk("r_queue_drained", exp_r.size(), 0);
    chk("cyc_queue_drained", cyc_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi4_user_yanker.md
AXI4_USER_YANKER -- requirements
Module: axi4_user_yanker

Interface
REQ-001 SHALL have parameter ID_W, default 4, giving the downstream AXI ID width.
REQ-002 SHALL have parameter DEPTH, default 2, giving the per-ID echo FIFO depth (power of two, at least 1).
REQ-003 SHALL have parameter ECHO_W, default 14, giving the echo width: extra_id 3 + tl_state_source 7 + tl_state_size 4.
REQ-004 SHALL have port clock, input, 1, the single clock; all state is updated on its rising edge.
REQ-005 SHALL have port reset, input, 1; reset is asynchronous and active-low.
REQ-006 SHALL have port group auto_in_aw_*, auto_in_ar_*, auto_in_w_*, auto_in_b_* and auto_in_r_*; this is the upstream AXI4 slave side.
REQ-007 SHALL give the upstream AW and AR groups: id ID_W; addr 32; len 8; size 3; burst 2; lock 1; cache 4; prot 3; qos 4; echo_tl_state_size 4; echo_tl_state_source 7; echo_extra_id 3.
REQ-008 SHALL have port group auto_out_*, the downstream AXI4 master side, with the same fields minus every echo_* field.
REQ-009 SHALL give W as data 64, strb 8, last 1; R as data 64, resp 2, last 1; B as resp 2.
REQ-010 SHALL have port resp_err, output, 1: sticky flag set when a response arrives for an ID whose queue is empty.

Function
REQ-011 SHALL pass every non-echo AW, AR and W field straight through from auto_in to auto_out, combinationally, with 0-cycle latency.
REQ-012 SHALL pass every B and R field except echo straight through from auto_out to auto_in, combinationally.
REQ-013 SHALL hold two banks of 2^ID_W FIFOs (AW/B bank, AR/R bank), each DEPTH entries of ECHO_W bits, each with a registered count.
REQ-014 SHALL drive auto_out_aw_valid = auto_in_aw_valid AND NOT full[aw_id], and auto_in_aw_ready = auto_out_aw_ready AND NOT full[aw_id]; AR is identical using the AR bank.
REQ-015 SHALL push the echo fields into the FIFO indexed by id on AW fire; AR fire does the same into the AR bank.
REQ-016 SHALL drive auto_in_b_echo_* from the head of AW/B FIFO[auto_out_b_bits_id]; auto_in_b_valid = auto_out_b_valid; auto_out_b_ready = auto_in_b_ready.
REQ-017 SHALL pop the AW/B FIFO on B fire.
REQ-018 SHALL drive auto_in_r_echo_* from the head of AR/R FIFO[auto_out_r_bits_id], and pop only on R fire with last=1; non-last beats leave the FIFO unchanged.
REQ-019 SHALL, when push and pop hit the same FIFO in one cycle, perform both, leaving the count unchanged.
REQ-020 SHALL take full from the registered count only: a full FIFO blocks the request even if a pop occurs the same cycle (no bypass).
REQ-021 SHALL take empty from the registered count only: a response arriving in the same cycle as the first push to that ID counts as empty.
REQ-022 SHALL, on a response for an empty FIFO: drive echo outputs to 0, perform no pop (count stays 0), set resp_err the next cycle, and hold it until reset.
REQ-023 SHALL wrap the read and write pointers modulo DEPTH; count ranges 0..DEPTH.
REQ-024 SHALL keep the request path independent of W; W is never stalled by this block.

Reset
REQ-025 SHALL, while reset is low, zero all counts and pointers and clear resp_err; FIFO data need not be reset.
REQ-026 SHALL hold these reset output values: auto_in_aw_ready/ar_ready follow auto_out ready (all queues empty); echo outputs 0.
REQ-027 SHALL, on reset mid-operation, discard outstanding echo entries; a later response for them raises resp_err.

Structure
REQ-028 SHALL place ID_W, ECHO_W, the echo field offsets and the echo record typedef in shared package axi4_echo_pkg.
REQ-029 SHALL implement one sub-module, axi4_echo_fifo (single DEPTH x ECHO_W FIFO with count), instantiated 2 x 2^ID_W times.

Verification
REQ-030 SHALL cover: AW id=3, source=0x15, size=3, extra=5, accepted; later B id=3 -> auto_in_b_echo_tl_state_source=0x15, size=3, extra_id=5; queue[3] empty after.
REQ-031 SHALL cover: three AR id=7 with DEPTH=2 -> third held with auto_in_ar_ready=0 and auto_out_ar_valid=0 until an R last=1 for id 7 completes.
REQ-032 SHALL cover: 4-beat R burst id=2 -> echo constant on all 4 beats; pop only after beat 4.
REQ-033 SHALL cover: B id=9 with no prior AW -> echo outputs 0, resp_err=1 next cycle, still 1 after 10 idle cycles.
REQ-034 SHALL cover: queue[1] full, B pop and new AW id=1 in same cycle -> AW stalled that cycle, accepted the next; count stays 2.
REQ-035 SHALL cover: two AWs outstanding, reset pulsed low asynchronously mid-cycle -> counts 0 immediately, resp_err 0, aw_ready follows auto_out_aw_ready.
